ring_ctr_gen: RTL

Parametrised ring/Johnson counter for sequencing strobes, phase selects and round-robin pointers. Supports width set at elaboration, run-time mode select (one-hot ring or twisted-ring Johnson), shift direction, enable, parallel load, and a wrap pulse at the end of each full period. An optional self-check detects illegal patterns and forces recovery, replacing the fixed 4-bit right-rotating ring counter used so far.

---
 rtl/ring_ctr_gen_if.sv | 27 ++
 rtl/ring_ctr_gen.sv | 115 +++++++++++
 2 files changed

// File: rtl/ring_ctr_gen_if.sv
// rtl/ring_ctr_gen_if.sv - control/status bundle for ring_ctr_gen
//
// Groups the run-time controls and the registered outputs of the counter.
//   master : drives en, mode, dir, load, load_val; observes out, wrap, err
//   slave  : the counter itself (observes controls, drives out, wrap, err)
interface ring_ctr_gen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             err;

  modport master (
    output en, mode, dir, load, load_val,
    input  out, wrap, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output out, wrap, err
  );
endinterface

// File: rtl/ring_ctr_gen.sv
// rtl/ring_ctr_gen.sv - parametrised ring / Johnson counter with wrap pulse
//
// Purpose: sequencing counter that runs either as a one-hot ring (period
// WIDTH) or as a twisted-ring Johnson counter (period 2*WIDTH), shifting
// toward LSB or MSB, with enable, parallel load and a one-cycle wrap pulse
// whenever a shift lands on the seed pattern of the current mode.
//
// Optional macro RING_CTR_SELFCHECK_EN: compiles in the legality check that
// replaces an illegal pattern with the seed and pulses err. Without it err
// is tied low and illegal patterns simply shift.
//
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset (out = MSB one-hot, ring mode)
//   bus   - ring_ctr_gen_if.slave: en, mode, dir, load, load_val in;
//           out, wrap, err out (all registered)
//   WIDTH - number of state bits, 2..32
module ring_ctr_gen #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  ring_ctr_gen_if.slave   bus
);

  typedef logic [WIDTH-1:0] vec_t;

  vec_t out_q, out_d;
  logic mode_q, mode_d;
  logic wrap_q, wrap_d;

  // Ring seed is the MSB one-hot; Johnson seed is all zeros.
  function automatic vec_t seed(input logic m);
    return m ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  // One step of either counter; Johnson feeds back the inverted bit that
  // falls off the far end.
  function automatic vec_t step(input vec_t v, input logic m, input logic d);
    logic fb;
    if (d) begin
      fb = m ? ~v[WIDTH-1] : v[WIDTH-1];
      return {v[WIDTH-2:0], fb};
    end else begin
      fb = m ? ~v[0] : v[0];
      return {fb, v[WIDTH-1:1]};
    end
  endfunction

`ifdef RING_CTR_SELFCHECK_EN
  logic err_q, err_d;

  // Johnson states have a single boundary between a run of ones and a run
  // of zeros, so at most one adjacent pair may differ.
  function automatic logic legal(input vec_t v, input logic m);
    if (m)
      return $countones(v[WIDTH-2:0] ^ v[WIDTH-1:1]) <= 1;
    else
      return $countones(v) == 1;
  endfunction
`endif

  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
`ifdef RING_CTR_SELFCHECK_EN
    err_d  = 1'b0;
`endif
    if (bus.load) begin
      // load_val is taken under the mode presented on the same edge
      out_d  = bus.load_val;
      mode_d = bus.mode;
    end
`ifdef RING_CTR_SELFCHECK_EN
    else if (!legal(out_q, mode_q)) begin
      out_d = seed(mode_q);
      err_d = 1'b1;
    end
`endif
    else if (bus.mode != mode_q) begin
      out_d  = seed(bus.mode);
      mode_d = bus.mode;
    end else if (bus.en) begin
      out_d  = step(out_q, mode_q, bus.dir);
      wrap_d = (out_d == seed(mode_q));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= seed(1'b0);
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef RING_CTR_SELFCHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.out  = out_q;
  assign bus.wrap = wrap_q;

endmodule
